// File: rtl/cpu_pkg.sv
// Shared core definitions: controller phase encodings, the reset NOP, and
// fetch-stage enums plus the next-PC source selector.
package cpu_pkg;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WRITE  = 3'd4;

   // addi x0,x0,0; opcode 0 decodes as IN, so it cannot serve as the idle word
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      FS_IDLE  = 3'd0,
      FS_REQ   = 3'd1,
      FS_WAIT  = 3'd2,
      FS_DONE  = 3'd3,
      FS_DRAIN = 3'd4
   } fetch_st_t;

   typedef enum logic [1:0] {
      NPC_SEQ  = 2'd0,
      NPC_REL  = 2'd1,
      NPC_JALR = 2'd2
   } npc_sel_t;

   // Unconditional jumps take priority over a taken conditional branch.
   function automatic npc_sel_t npc_select(input logic branch_uc,
                                           input logic branch_c,
                                           input logic branch_relative,
                                           input logic cond_true);
      npc_sel_t sel;
      sel = NPC_SEQ;
      if (branch_uc)
         sel = branch_relative ? NPC_REL : NPC_JALR;
      else if (branch_c && cond_true)
         sel = NPC_REL;
      return sel;
   endfunction

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, pc-relative (jal / taken
// branch) or register-indirect (jalr), with a word-alignment flag.
module next_pc_calc
   import cpu_pkg::*;
(
   input  logic [31:0] i_pc,
   input  logic [31:0] i_imm,
   input  logic [31:0] i_alu_result,
   input  logic        i_branch_uc,
   input  logic        i_branch_c,
   input  logic        i_branch_relative,
   output logic [31:0] o_next_pc,
   output logic [31:0] o_pc_plus4,
   output logic        o_misalign
);

   npc_sel_t    w_sel;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_rel;
   logic [31:0] w_jalr_tgt;
   logic [31:0] w_next_pc;

   assign w_pc_plus4 = i_pc + 32'd4;
   assign w_pc_rel   = i_pc + i_imm;
   assign w_jalr_tgt = {i_alu_result[31:1], 1'b0};

   assign w_sel = npc_select(i_branch_uc, i_branch_c, i_branch_relative,
                             i_alu_result[0]);

   always_comb begin
      // NOTE: assign a default before the case so no path leaves the net
      // unassigned, which would otherwise infer a latch.
      w_next_pc = w_pc_plus4;
      case (w_sel)
         NPC_REL:  w_next_pc = w_pc_rel;
         NPC_JALR: w_next_pc = w_jalr_tgt;
         default:  w_next_pc = w_pc_plus4;
      endcase
   end

   assign o_next_pc  = w_next_pc;
   assign o_pc_plus4 = w_pc_plus4;
   assign o_misalign = is_misaligned(w_next_pc);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs one imem read per FETCH phase
// and holds the fetched word for decode; commits the next PC in WRITE.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  state,
   input  logic        branch_uc,
   input  logic        branch_c,
   input  logic        branch_relative,
   input  logic [31:0] imm,
   input  logic [31:0] alu_result,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_raw,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_done,
   output logic        misalign_err
);

   fetch_st_t   r_fsm;
   logic        r_imem_req;
   logic        r_fetch_done;
   logic [31:0] r_instr_raw;
   logic [31:0] r_pc;
   logic        r_commit_done;
   logic        r_misalign_err;

   logic        w_in_fetch;
   logic        w_in_write;
   logic [31:0] w_next_pc;
   logic [31:0] w_pc_plus4;
   logic        w_misalign;

   assign w_in_fetch = (state == ST_FETCH);
   assign w_in_write = (state == ST_WRITE);

   next_pc_calc u_next_pc_calc (
      .i_pc              (r_pc),
      .i_imm             (imm),
      .i_alu_result      (alu_result),
      .i_branch_uc       (branch_uc),
      .i_branch_c        (branch_c),
      .i_branch_relative (branch_relative),
      .o_next_pc         (w_next_pc),
      .o_pc_plus4        (w_pc_plus4),
      .o_misalign        (w_misalign)
   );

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm        <= FS_IDLE;
         r_imem_req   <= 1'b0;
         r_fetch_done <= 1'b0;
         r_instr_raw  <= NOP_INSTR;
      end else begin
         r_fetch_done <= 1'b0;
         case (r_fsm)
            FS_IDLE: begin
               if (w_in_fetch && !r_misalign_err) begin
                  r_fsm      <= FS_REQ;
                  r_imem_req <= 1'b1;
               end
            end
            FS_REQ: begin
               // An accepted request must still see its response, even if
               // the phase ended on the acceptance cycle.
               if (imem_ready) begin
                  r_imem_req <= 1'b0;
                  r_fsm      <= w_in_fetch ? FS_WAIT : FS_DRAIN;
               end else if (!w_in_fetch) begin
                  r_imem_req <= 1'b0;
                  r_fsm      <= FS_IDLE;
               end
            end
            FS_WAIT: begin
               if (imem_rvalid) begin
                  if (w_in_fetch) begin
                     r_instr_raw  <= imem_rdata;
                     r_fetch_done <= 1'b1;
                     r_fsm        <= FS_DONE;
                  end else begin
                     r_fsm <= FS_IDLE;
                  end
               end else if (!w_in_fetch) begin
                  r_fsm <= FS_DRAIN;
               end
            end
            FS_DRAIN: begin
               if (imem_rvalid)
                  r_fsm <= FS_IDLE;
            end
            FS_DONE: begin
               if (!w_in_fetch)
                  r_fsm <= FS_IDLE;
            end
            default: begin
               r_fsm      <= FS_IDLE;
               r_imem_req <= 1'b0;
            end
         endcase
      end
   end

   // One commit per WRITE phase; the flag re-arms once the phase ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc           <= RESET_PC;
         r_commit_done  <= 1'b0;
         r_misalign_err <= 1'b0;
      end else if (w_in_write) begin
         if (!r_commit_done) begin
            r_commit_done <= 1'b1;
            if (w_misalign)
               r_misalign_err <= 1'b1;
            else
               r_pc <= w_next_pc;
         end
      end else begin
         r_commit_done <= 1'b0;
      end
   end

   assign imem_req     = r_imem_req;
   assign imem_addr    = r_pc;
   assign instr_raw    = r_instr_raw;
   assign pc           = r_pc;
   assign pc_plus4     = w_pc_plus4;
   assign fetch_done   = r_fetch_done;
   assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// fetch/write rounds checked against a simple PC / instruction model.
module tb_fetch_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  state;
   logic        branch_uc, branch_c, branch_relative;
   logic [31:0] imm, alu_result;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready, imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr_raw, pc, pc_plus4;
   logic        fetch_done, misalign_err;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_pc;
   logic [31:0] m_instr;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .state           (state),
      .branch_uc       (branch_uc),
      .branch_c        (branch_c),
      .branch_relative (branch_relative),
      .imm             (imm),
      .alu_result      (alu_result),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .instr_raw       (instr_raw),
      .pc              (pc),
      .pc_plus4        (pc_plus4),
      .fetch_done      (fetch_done),
      .misalign_err    (misalign_err)
   );

   // Reference next-PC: derived directly from the branch rules.
   function automatic logic [31:0] model_target(input logic [31:0] cur,
                                                input logic uc, input logic c,
                                                input logic rel,
                                                input logic [31:0] imm_v,
                                                input logic [31:0] alu_v);
      if (uc && rel)          return cur + imm_v;
      if (uc)                 return alu_v - (alu_v % 2);
      if (c && (alu_v % 2))   return cur + imm_v;
      return cur + 32'd4;
   endfunction

   task automatic apply_reset();
      rst = 1'b1;
      state = ST_DECODE;
      imem_ready = 1'b0;
      imem_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_pc = 32'h0;
      m_instr = NOP_INSTR;
   endtask

   // Runs one FETCH phase with a memory that accepts after rdy_lat request
   // cycles and answers rv_lat cycles after the accepting cycle; a spurious
   // rvalid with other data is presented once the fetch has completed.
   task automatic run_fetch(input logic [31:0] data, input int rdy_lat,
                            input int rv_lat, input int max_cyc,
                            output int done_at, output int pulses,
                            output int reqs, output int addr_bad);
      int req_cnt;
      int acc_cyc;
      done_at = -1; pulses = 0; reqs = 0; addr_bad = 0;
      req_cnt = 0; acc_cyc = -1;
      state = ST_FETCH;
      imem_ready = 1'b0;
      imem_rvalid = 1'b0;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         @(negedge clk);
         imem_ready = 1'b0;
         imem_rvalid = 1'b0;
         imem_rdata = $urandom;
         if (fetch_done) begin
            pulses++;
            if (done_at < 0) done_at = cyc;
         end
         if (imem_req && imem_addr !== m_pc) addr_bad++;
         if (imem_req) begin
            if (acc_cyc < 0) begin
               if (req_cnt == rdy_lat) begin
                  imem_ready = 1'b1;
                  acc_cyc = cyc;
                  reqs++;
               end else begin
                  req_cnt++;
               end
            end else begin
               reqs++;
            end
         end
         if (acc_cyc >= 0 && cyc == acc_cyc + 1 + rv_lat) begin
            imem_rvalid = 1'b1;
            imem_rdata = data;
         end
         if (done_at > 0 && cyc == done_at) begin
            imem_rvalid = 1'b1;
            imem_rdata = ~data;
         end
         if (done_at > 0 && cyc >= done_at + 2) break;
      end
      state = ST_DECODE;
      imem_ready = 1'b0;
      imem_rvalid = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_write(input logic uc, input logic c, input logic rel,
                            input logic [31:0] imm_v, input logic [31:0] alu_v,
                            input int hold,
                            output logic [31:0] pc_first,
                            output logic [31:0] pc_last);
      branch_uc = uc;
      branch_c = c;
      branch_relative = rel;
      imm = imm_v;
      alu_result = alu_v;
      state = ST_WRITE;
      @(negedge clk);
      pc_first = pc;
      repeat (hold - 1) @(negedge clk);
      pc_last = pc;
      state = ST_DECODE;
      branch_uc = 1'b0;
      branch_c = 1'b0;
      branch_relative = 1'b0;
      imm = $urandom;
      alu_result = $urandom;
      @(negedge clk);
   endtask

   task automatic test_reset();
      checks++;
      if (pc !== 32'h0) begin
         failures++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0);
      end
      checks++;
      if (instr_raw !== 32'h0000_0013) begin
         failures++; $display("FAIL reset_instr: got %h want %h", instr_raw, 32'h13);
      end
      checks++;
      if ({imem_req, fetch_done, misalign_err} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: got req/done/err=%b want 000",
                  {imem_req, fetch_done, misalign_err});
      end
      checks++;
      if (pc_plus4 !== 32'h4) begin
         failures++; $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, 32'h4);
      end
   endtask

   task automatic test_fetch_basic();
      int done_at, pulses, reqs, addr_bad;
      run_fetch(32'h0050_0093, 0, 0, 20, done_at, pulses, reqs, addr_bad);
      checks++;
      if (done_at != 3 || pulses != 1) begin
         failures++;
         $display("FAIL fetch_timing: got done_at=%0d pulses=%0d want 3/1", done_at, pulses);
      end
      checks++;
      if (reqs != 1 || addr_bad != 0) begin
         failures++;
         $display("FAIL fetch_req: got reqs=%0d bad_addr=%0d want 1/0", reqs, addr_bad);
      end
      checks++;
      if (instr_raw !== 32'h0050_0093) begin
         failures++; $display("FAIL fetch_instr: got %h want %h", instr_raw, 32'h0050_0093);
      end
      m_instr = 32'h0050_0093;
   endtask

   task automatic test_write_seq();
      logic [31:0] pf, pl;
      run_write(1'b1, 1'b0, 1'b0, 32'h0, 32'h10, 1, pf, pl);
      run_write(1'b0, 1'b0, 1'b0, 32'h40, 32'h1, 5, pf, pl);
      checks++;
      if (pf !== 32'h14) begin
         failures++; $display("FAIL seq_pc: got %h want %h", pf, 32'h14);
      end
      checks++;
      if (pl !== 32'h14 || pc !== 32'h14) begin
         failures++; $display("FAIL seq_single_commit: got %h want %h", pc, 32'h14);
      end
      m_pc = 32'h14;
   endtask

   task automatic test_jal_jalr();
      logic [31:0] pf, pl;
      run_write(1'b1, 1'b0, 1'b0, 32'h0, 32'h20, 1, pf, pl);
      run_write(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0, 2, pf, pl);
      checks++;
      if (pc !== 32'h18) begin
         failures++; $display("FAIL jal_pc: got %h want %h", pc, 32'h18);
      end
      run_write(1'b1, 1'b0, 1'b0, 32'h4, 32'h101, 2, pf, pl);
      checks++;
      if (pc !== 32'h100 || pc_plus4 !== 32'h104) begin
         failures++;
         $display("FAIL jalr_pc: got pc=%h pc_plus4=%h want 100/104", pc, pc_plus4);
      end
      m_pc = 32'h100;
   endtask

   task automatic test_branch_c();
      logic [31:0] pf, pl;
      run_write(1'b1, 1'b0, 1'b0, 32'h0, 32'h8, 1, pf, pl);
      run_write(1'b0, 1'b1, 1'b0, 32'h40, 32'h1, 1, pf, pl);
      checks++;
      if (pc !== 32'h48) begin
         failures++; $display("FAIL branch_taken: got %h want %h", pc, 32'h48);
      end
      run_write(1'b1, 1'b0, 1'b0, 32'h0, 32'h8, 1, pf, pl);
      run_write(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1, pf, pl);
      checks++;
      if (pc !== 32'hC) begin
         failures++; $display("FAIL branch_not_taken: got %h want %h", pc, 32'hC);
      end
      m_pc = 32'hC;
   endtask

   task automatic test_abort();
      int pulses;
      int done_at, p2, reqs, addr_bad;
      state = ST_FETCH;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1) begin
         failures++; $display("FAIL abort_req_up: got %b want 1", imem_req);
      end
      state = ST_DECODE;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0) begin
         failures++; $display("FAIL abort_req_withdrawn: got %b want 0", imem_req);
      end
      state = ST_FETCH;
      @(negedge clk);
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      state = ST_DECODE;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         imem_rvalid = (i == 2);
         imem_rdata = 32'hDEAD_BEEF;
         @(negedge clk);
         if (fetch_done) pulses++;
      end
      imem_rvalid = 1'b0;
      checks++;
      if (pulses != 0 || instr_raw !== m_instr) begin
         failures++;
         $display("FAIL abort_wait: got pulses=%0d instr=%h want 0/%h", pulses, instr_raw, m_instr);
      end
      run_fetch(32'h1234_5678, 1, 1, 20, done_at, p2, reqs, addr_bad);
      checks++;
      if (done_at != 5 || p2 != 1 || reqs != 1 || instr_raw !== 32'h1234_5678) begin
         failures++;
         $display("FAIL abort_recover: got done_at=%0d pulses=%0d reqs=%0d instr=%h want 5/1/1/12345678",
                  done_at, p2, reqs, instr_raw);
      end
      m_instr = 32'h1234_5678;
   endtask

   task automatic test_misalign();
      logic [31:0] pf, pl;
      int done_at, pulses, reqs, addr_bad;
      apply_reset();
      run_write(1'b1, 1'b0, 1'b1, 32'h6, 32'h0, 1, pf, pl);
      checks++;
      if (pc !== 32'h0 || misalign_err !== 1'b1) begin
         failures++;
         $display("FAIL misalign_hold: got pc=%h err=%b want 0/1", pc, misalign_err);
      end
      run_fetch(32'hAAAA_5555, 0, 0, 8, done_at, pulses, reqs, addr_bad);
      checks++;
      if (reqs != 0 || pulses != 0 || misalign_err !== 1'b1) begin
         failures++;
         $display("FAIL misalign_no_fetch: got reqs=%0d pulses=%0d err=%b want 0/0/1",
                  reqs, pulses, misalign_err);
      end
      apply_reset();
      checks++;
      if (misalign_err !== 1'b0) begin
         failures++; $display("FAIL misalign_clear: got %b want 0", misalign_err);
      end
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] pf, pl;
      int done_at, pulses, reqs, addr_bad;
      run_write(1'b1, 1'b0, 1'b0, 32'h0, 32'h40, 1, pf, pl);
      m_pc = 32'h40;
      run_fetch(32'h0FF0_0F0F, 0, 0, 20, done_at, pulses, reqs, addr_bad);
      state = ST_FETCH;
      @(negedge clk);
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      rst = 1'b1;
      state = ST_DECODE;
      @(negedge clk);
      rst = 1'b0;
      m_pc = 32'h0;
      m_instr = NOP_INSTR;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         imem_rvalid = (i == 0);
         imem_rdata = 32'hCAFE_F00D;
         @(negedge clk);
         if (fetch_done) pulses++;
      end
      imem_rvalid = 1'b0;
      checks++;
      if (instr_raw !== NOP_INSTR || pc !== 32'h0) begin
         failures++;
         $display("FAIL rst_wait_state: got instr=%h pc=%h want %h/0", instr_raw, pc, NOP_INSTR);
      end
      checks++;
      if (pulses != 0 || imem_req !== 1'b0) begin
         failures++;
         $display("FAIL rst_wait_late_rvalid: got pulses=%0d req=%b want 0/0", pulses, imem_req);
      end
   endtask

   task automatic test_random();
      int done_at, pulses, reqs, addr_bad, rl, vl, kind, hold;
      logic [31:0] data, imm_v, alu_v, exp, pf, pl;
      logic uc, c, rel;
      for (int it = 0; it < 25; it++) begin
         data = $urandom;
         rl = $urandom_range(0, 3);
         vl = $urandom_range(0, 3);
         run_fetch(data, rl, vl, 40, done_at, pulses, reqs, addr_bad);
         checks++;
         if (done_at != 3 + rl + vl || pulses != 1 || reqs != 1 || addr_bad != 0) begin
            failures++;
            $display("FAIL rnd_fetch[%0d]: got done_at=%0d pulses=%0d reqs=%0d bad=%0d want %0d/1/1/0",
                     it, done_at, pulses, reqs, addr_bad, 3 + rl + vl);
         end
         checks++;
         if (instr_raw !== data) begin
            failures++; $display("FAIL rnd_instr[%0d]: got %h want %h", it, instr_raw, data);
         end
         kind = $urandom_range(0, 3);
         imm_v = $urandom & 32'hFFFF_FFFC;
         alu_v = $urandom;
         rel = $urandom_range(0, 1);
         uc = 1'b0;
         c = 1'b0;
         case (kind)
            1: begin uc = 1'b1; rel = 1'b1; end
            2: begin uc = 1'b1; rel = 1'b0; alu_v = alu_v & 32'hFFFF_FFFD; end
            3: c = 1'b1;
            default: ;
         endcase
         exp = model_target(m_pc, uc, c, rel, imm_v, alu_v);
         hold = $urandom_range(1, 4);
         run_write(uc, c, rel, imm_v, alu_v, hold, pf, pl);
         checks++;
         if (pf !== exp || pl !== exp || pc_plus4 !== exp + 32'd4) begin
            failures++;
            $display("FAIL rnd_pc[%0d]: got first=%h last=%h plus4=%h want %h kind=%0d",
                     it, pf, pl, pc_plus4, exp, kind);
         end
         m_pc = exp;
      end
   endtask

   initial begin
      rst = 1'b1;
      state = ST_DECODE;
      branch_uc = 1'b0;
      branch_c = 1'b0;
      branch_relative = 1'b0;
      imm = 32'h0;
      alu_result = 32'h0;
      imem_ready = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = 32'h0;
      repeat (3) @(negedge clk);
      apply_reset();
      test_reset();
      test_fetch_basic();
      test_write_seq();
      test_jal_jalr();
      test_branch_c();
      test_abort();
      test_misalign();
      test_reset_in_wait();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the multi-cycle core, directly upstream of the decode stage. Owns the program counter, issues one instruction-memory read per FETCH phase over a valid/ready request plus read-valid response handshake, and holds the fetched word stable on `instr_raw` for decode. In the WRITE phase it commits the next PC from decode's branch controls, the immediate and the ALU result.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `state`  in  3  controller phase: FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4
- `branch_uc`, `branch_c`, `branch_relative`  in  1 each  decode branch controls
- `imm`  in  32  decoded immediate
- `alu_result`  in  32  ALU output: jalr target, or branch compare result in bit 0
- `imem_req`  out  1  read request valid
- `imem_addr`  out  32  read address, equal to `pc`
- `imem_ready`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  read data valid
- `imem_rdata`  in  32  read data
- `instr_raw`  out  32  latched instruction, to decode
- `pc`  out  32  current PC
- `pc_plus4`  out  32  `pc + 4`, the link value for jal/jalr
- `fetch_done`  out  1  one-cycle pulse when `instr_raw` is updated
- `misalign_err`  out  1  sticky: a misaligned next PC was computed

## Operation
- Fetch FSM states:
  - IDLE: if `state==0` and `!misalign_err`, go to REQ.
  - REQ: `imem_req=1`. On `imem_ready`, go to WAIT.
  - WAIT: on `imem_rvalid`, latch `instr_raw<=imem_rdata`, pulse `fetch_done`, go to DONE.
  - DONE: hold. When `state!=0`, go to IDLE.
- Exactly one request is issued per FETCH phase.
- `imem_rvalid` in any FSM state other than WAIT is ignored.
- If `state` leaves 0 while the FSM is in REQ:
  - the request is withdrawn and the FSM returns to IDLE.
- If `state` leaves 0 while the FSM is in WAIT:
  - the FSM stays in WAIT until `imem_rvalid`, then goes to IDLE;
  - `instr_raw` is not updated and no `fetch_done` pulse is produced.
- Next-PC selection, all arithmetic modulo 2^32:
  - `branch_uc && !branch_relative` (jalr): `alu_result & ~1`.
  - `branch_uc && branch_relative` (jal): `pc + imm`.
  - `branch_c && alu_result[0]`: `pc + imm`.
  - otherwise: `pc + 4`.
- PC commit: exactly once per WRITE phase, on the first cycle with `state==4`. An internal flag blocks further commits and is cleared when `state!=4`.
- Misaligned target (next `[1:0]!=0`):
  - `pc` is held and `misalign_err` is set;
  - while `misalign_err` is set, no further fetch requests are issued;
  - only `rst` clears it.
- Reset values:
  - `pc=RESET_PC`, FSM=IDLE, `imem_req=0`, `fetch_done=0`, `misalign_err=0`, commit flag cleared.
  - `instr_raw=32'h0000_0013` (addi x0,x0,0 NOP). The value 0 is not used because decode treats opcode 0 as the IN instruction.
- Reset in any FSM state aborts the transaction. A stale `imem_rvalid` arriving after reset is ignored because the FSM is in IDLE.

## Timing
- `imem_req` rises the cycle after `state` becomes 0 (IDLE→REQ is registered).
- `imem_rvalid` arrives no earlier than the cycle after acceptance. Minimum fetch latency is 3 cycles from entering FETCH to `fetch_done`.
- `instr_raw` and `fetch_done` are registered. `instr_raw` is stable from the `fetch_done` cycle until the next `fetch_done` or reset.
- `pc` updates the cycle after the first `state==4` cycle. `pc_plus4` is combinational from `pc`.
- `imem_addr` is held constant while `imem_req` is high.

## Structure
- Shared package `cpu_pkg`:
  - phase constants `ST_FETCH`..`ST_WRITE`;
  - `NOP_INSTR = 32'h0000_0013`;
  - fetch FSM enum `fetch_st_t`.
- The controller and decode stage import the phase constants from `cpu_pkg` rather than using literals.
- Sub-module `next_pc_calc`: combinational next-PC mux plus adders, with a misalign output.
- The FSM, PC register and `instr_raw` latch live in `fetch_unit`.

## Test plan
- Reset, then FETCH with `imem_ready=1` and `imem_rdata=32'h00500093` returned the next cycle:
  - `imem_addr=0`;
  - `fetch_done` pulses once 3 cycles after entering FETCH;
  - `instr_raw=32'h00500093`.
- WRITE with no branch, `pc=0x10`: `pc=0x14`. Holding `state=4` for 5 cycles commits only once.
- jal with `imm=-8` at `pc=0x20`: `pc=0x18`. jalr with `alu_result=0x101`: `pc=0x100`.
- `branch_c=1`, `imm=0x40`, `pc=0x8`:
  - with `alu_result=1`: `pc=0x48`;
  - with `alu_result=0`: `pc=0xC`.
- jal with `imm=0x6` from `pc=0`: `pc` stays 0, `misalign_err=1`, and `imem_req` stays 0 in the next FETCH.
- `rst` asserted while in WAIT:
  - `instr_raw=NOP_INSTR` and `pc=RESET_PC`;
  - a late `imem_rvalid` is ignored and no `fetch_done` pulse occurs.
